// File: rtl/vedic8_seq_mul.sv
// Sequential 8x8 unsigned multiplier: one 4x4 Vedic core, four nibble passes into a 16-bit accumulator.
// Optional completed-operation counter (op_count port) when VEDIC8_OPCNT_EN is defined.

module vedic2mul (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] p
);
  logic t0, t1, hi, c;
  assign t0 = a[1] & b[0];
  assign t1 = a[0] & b[1];
  assign hi = a[1] & b[1];
  assign c  = t0 & t1;
  assign p  = {hi & c, hi ^ c, t0 ^ t1, a[0] & b[0]};
endmodule

module vedic4mul (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  logic [3:0] q0, q1, q2, q3;
  logic [4:0] mid;

  vedic2mul u_ll (.a(a[1:0]), .b(b[1:0]), .p(q0));
  vedic2mul u_hl (.a(a[3:2]), .b(b[1:0]), .p(q1));
  vedic2mul u_lh (.a(a[1:0]), .b(b[3:2]), .p(q2));
  vedic2mul u_hh (.a(a[3:2]), .b(b[3:2]), .p(q3));

  // Vertical-and-crosswise: cross terms summed once, then weighted by 4
  assign mid = {1'b0, q1} + {1'b0, q2};
  assign p   = {4'b0000, q0} + {1'b0, mid, 2'b00} + {q3, 4'b0000};
endmodule

// state | meaning
// IDLE  | in_ready=1, waiting for an operand pair
// MUL   | one nibble-pair pass per cycle, step 0..3
// DONE  | out_valid=1, p held until out_ready
module vedic8_seq_mul #(
  parameter logic SKIP_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] p
`ifdef VEDIC8_OPCNT_EN
  ,
  output logic [15:0] op_count
`endif
);
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t      state;
  logic [7:0]  a_r, b_r;
  logic [1:0]  step;
  logic [15:0] acc;
  logic [3:0]  core_a, core_b;
  logic [7:0]  core_p;
  logic [15:0] addend;
  logic [15:0] sum;
  logic        op_zero;

  vedic4mul u_core (.a(core_a), .b(core_b), .p(core_p));

  always_comb begin
    core_a = a_r[3:0];
    core_b = b_r[3:0];
    addend = {8'h00, core_p};
    case (step)
      2'd1: begin
        core_a = a_r[7:4];
        addend = {4'h0, core_p, 4'h0};
      end
      2'd2: begin
        core_b = b_r[7:4];
        addend = {4'h0, core_p, 4'h0};
      end
      2'd3: begin
        core_a = a_r[7:4];
        core_b = b_r[7:4];
        addend = {core_p, 8'h00};
      end
      default: ;
    endcase
  end

  assign sum     = acc + addend;
  assign op_zero = (a_r == 8'h00) || (b_r == 8'h00);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      p         <= 16'h0000;
      step      <= 2'd0;
      a_r       <= 8'h00;
      b_r       <= 8'h00;
      acc       <= 16'h0000;
`ifdef VEDIC8_OPCNT_EN
      op_count  <= 16'h0000;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r      <= a;
            b_r      <= b;
            acc      <= 16'h0000;
            step     <= 2'd0;
            in_ready <= 1'b0;
            state    <= MUL;
          end
        end
        MUL: begin
          // Zero operands are resolved in the first pass slot, giving a one-cycle completion
          if ((SKIP_ZERO == 1'b1) && (step == 2'd0) && op_zero) begin
            p         <= 16'h0000;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            acc  <= sum;
            step <= step + 2'd1;
            if (step == 2'd3) begin
              p         <= sum;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
`ifdef VEDIC8_OPCNT_EN
            op_count  <= op_count + 16'd1;
`endif
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_vedic8_seq_mul.sv
// Directed-vector bench for vedic8_seq_mul; second instance covers SKIP_ZERO=0.
module tb_vedic8_seq_mul;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  a, b;
  logic [15:0] p;
  logic        z_in_valid, z_in_ready, z_out_valid, z_out_ready;
  logic [7:0]  za, zb;
  logic [15:0] zp;
`ifdef VEDIC8_OPCNT_EN
  logic [15:0] op_count, z_op_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vedic8_seq_mul #(.SKIP_ZERO(1'b1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .p(p)
`ifdef VEDIC8_OPCNT_EN
    , .op_count(op_count)
`endif
  );

  vedic8_seq_mul #(.SKIP_ZERO(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(z_in_valid), .in_ready(z_in_ready),
    .a(za), .b(zb), .out_valid(z_out_valid), .out_ready(z_out_ready), .p(zp)
`ifdef VEDIC8_OPCNT_EN
    , .op_count(z_op_count)
`endif
  );

  typedef struct {
    logic [7:0]  va;
    logic [7:0]  vb;
    logic [15:0] vp;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [7:0] va, input logic [7:0] vb,
                        output logic [15:0] pg, output int lat);
    in_valid = 1'b1; a = va; b = vb;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    pg = p;
  endtask

  task automatic zrun_op(input logic [7:0] va, input logic [7:0] vb,
                         output logic [15:0] pg, output int lat);
    z_in_valid = 1'b1; za = va; zb = vb;
    tick();
    z_in_valid = 1'b0;
    lat = 0;
    while (!z_out_valid && lat < 20) begin
      tick();
      lat++;
    end
    pg = zp;
  endtask

  initial begin
    logic [15:0] pg, ev, pv;
    logic [7:0]  ra, rb;
    int lat, ir_low, ov_hi, rise, tries;
    bit done;

    vecs[0]  = '{8'd13,  8'd11,  16'd143,   4};
    vecs[1]  = '{8'd255, 8'd255, 16'd65025, 4};
    vecs[2]  = '{8'd0,   8'd200, 16'd0,     1};
    vecs[3]  = '{8'd7,   8'd9,   16'd63,    4};
    vecs[4]  = '{8'd100, 8'd3,   16'd300,   4};
    vecs[5]  = '{8'd1,   8'd1,   16'd1,     4};
    vecs[6]  = '{8'd16,  8'd16,  16'd256,   4};
    vecs[7]  = '{8'd15,  8'd15,  16'd225,   4};
    vecs[8]  = '{8'd240, 8'd15,  16'd3600,  4};
    vecs[9]  = '{8'd170, 8'd85,  16'd14450, 4};
    vecs[10] = '{8'd200, 8'd0,   16'd0,     1};
    vecs[11] = '{8'd128, 8'd2,   16'd256,   4};

    rst = 1'b1; in_valid = 1'b0; a = 8'd0; b = 8'd0; out_ready = 1'b1;
    z_in_valid = 1'b0; za = 8'd0; zb = 8'd0; z_out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;

    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_p", p, 0);
`ifdef VEDIC8_OPCNT_EN
    check("reset_op_count", op_count, 0);
`endif

    // 13*11 with detailed handshake timing
    in_valid = 1'b1; a = 8'd13; b = 8'd11;
    tick();
    in_valid = 1'b0;
    ir_low = 0; ov_hi = 0; rise = -1; pv = 16'd0;
    for (int k = 0; k < 8; k++) begin
      if (!in_ready) ir_low++;
      if (out_valid) begin
        ov_hi++;
        if (rise < 0) rise = k;
        pv = p;
      end
      tick();
    end
    check("t1_in_ready_low_cycles", ir_low, 5);
    check("t1_out_valid_cycles", ov_hi, 1);
    check("t1_latency", rise, 4);
    check("t1_p", pv, 143);

    for (int i = 0; i < 12; i++) begin
      check($sformatf("vec%0d_in_ready", i), in_ready, 1);
      run_op(vecs[i].va, vecs[i].vb, pg, lat);
      check($sformatf("vec%0d_p", i), pg, vecs[i].vp);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      tick();
      check($sformatf("vec%0d_out_valid_cleared", i), out_valid, 0);
    end

    // 255*255 held under back-pressure
    out_ready = 1'b0;
    run_op(8'd255, 8'd255, pg, lat);
    check("stall_latency", lat, 4);
    for (int i = 0; i < 4; i++) begin
      check("stall_out_valid", out_valid, 1);
      check("stall_p", p, 65025);
      check("stall_in_ready", in_ready, 0);
      if (i < 3) tick();
    end
    out_ready = 1'b1;
    tick();
    check("stall_release_out_valid", out_valid, 0);
    check("stall_release_in_ready", in_ready, 1);

    // operands offered during MUL must be ignored
    in_valid = 1'b1; a = 8'd20; b = 8'd30;
    tick();
    a = 8'd7; b = 8'd9;
    tick(); tick(); tick();
    in_valid = 1'b0; a = 8'd0; b = 8'd0;
    lat = 3;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("ignore_latency", lat, 4);
    check("ignore_p", p, 600);
    tick();
    run_op(8'd7, 8'd9, pg, lat);
    check("after_ignore_p", pg, 63);
    tick();

    // reset while at step 2
    in_valid = 1'b1; a = 8'd100; b = 8'd3;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_out_valid", out_valid, 0);
    check("abort_p", p, 0);
    check("abort_in_ready", in_ready, 1);
    ov_hi = 0;
    for (int k = 0; k < 4; k++) begin
      if (out_valid) ov_hi++;
      tick();
    end
    check("abort_no_stale_output", ov_hi, 0);
    run_op(8'd100, 8'd3, pg, lat);
    check("after_abort_p", pg, 300);
    check("after_abort_latency", lat, 4);
    tick();

    // SKIP_ZERO=0 instance
    zrun_op(8'd5, 8'd5, pg, lat);
    check("noskip_5x5_p", pg, 25);
    tick();
    zrun_op(8'd0, 8'd200, pg, lat);
    check("noskip_zero_p", pg, 0);
    check("noskip_zero_latency", lat, 4);
    tick();
    check("noskip_out_valid_cleared", z_out_valid, 0);

    // 50 back-to-back random pairs with random back-pressure
    rst = 1'b1;
    tick();
    rst = 1'b0;
`ifdef VEDIC8_OPCNT_EN
    check("rand_op_count_start", op_count, 0);
`endif
    for (int n = 0; n < 50; n++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      if (n % 10 == 3) ra = 8'd0;
      ev = {8'd0, ra} * {8'd0, rb};
      tries = 0;
      while (!in_ready && tries < 20) begin
        tick();
        tries++;
      end
      check("rand_in_ready", in_ready, 1);
      in_valid = 1'b1; a = ra; b = rb;
      tick();
      in_valid = 1'b0;
      done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
        out_ready = 1'($urandom_range(0, 1));
        if (out_valid) begin
          check($sformatf("rand%0d_p", n), p, ev);
          if (out_ready) done = 1'b1;
        end
        tick();
      end
      if (!done) check($sformatf("rand%0d_timeout", n), 0, 1);
    end
    out_ready = 1'b1;
`ifdef VEDIC8_OPCNT_EN
    check("rand_op_count", op_count, 50);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
